montgomery_exp_ctrl: RTL and testbench

Sequencer that computes a modular exponentiation by driving one external `montgomery` multiplier through its start/done handshake. It uses a left-to-right binary square-and-multiply schedule. The block sits between the top-level RSA control and the multiplier, owns the multiplier's operand buses, and holds the accumulator. Operands arrive already in the Montgomery domain. The final multiplication by 1 converts the result out of the domain.

---
 rtl/mont_pkg.sv | 27 ++
 rtl/montgomery_exp_ctrl.sv | 163 ++++++++++++++++
 tb/tb_montgomery_exp_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/mont_pkg.sv
// Shared definitions for the Montgomery exponentiation controller.
//   state_t : controller FSM states
//   sel_t   : second-operand select for the multiplier (square / multiply / convert)
//   N_DEF, E_DEF : default operand and exponent widths
package mont_pkg;

  localparam int unsigned N_DEF = 1024;
  localparam int unsigned E_DEF = 1024;

  typedef enum logic [2:0] {
    IDLE,
    SQ_GO,
    SQ_WAIT,
    MUL_GO,
    MUL_WAIT,
    OUT_GO,
    OUT_WAIT,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    SEL_SQ,
    SEL_MUL,
    SEL_ONE
  } sel_t;

endpackage

// File: rtl/montgomery_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving one external Montgomery
// multiplier through its start/done handshake. Operands arrive in the
// Montgomery domain; the final mont(A,1) converts the result out of it.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start               : run request, accepted only in IDLE
//   in_x, in_r, in_m    : base (Montgomery domain), R mod M, modulus
//   in_e, in_elen       : exponent and number of exponent bits to scan
//   result, done, busy  : final value, one-cycle completion pulse, run in flight
//   mul_start           : one-cycle multiplier launch
//   mul_a, mul_b, mul_m : multiplier operands (held from launch through mul_done)
//   mul_result, mul_done: multiplier product and its one-cycle valid pulse
module montgomery_exp_ctrl
  import mont_pkg::*;
#(
  parameter int unsigned N  = N_DEF,
  parameter int unsigned E  = E_DEF,
  parameter int unsigned LW = $clog2(E + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [N-1:0]  in_x,
  input  logic [N-1:0]  in_r,
  input  logic [N-1:0]  in_m,
  input  logic [E-1:0]  in_e,
  input  logic [LW-1:0] in_elen,
  output logic [N-1:0]  result,
  output logic          done,
  output logic          busy,
  output logic          mul_start,
  output logic [N-1:0]  mul_a,
  output logic [N-1:0]  mul_b,
  output logic [N-1:0]  mul_m,
  input  logic [N-1:0]  mul_result,
  input  logic          mul_done
);

  state_t        r_state;
  state_t        w_next;
  sel_t          w_sel;
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_x;
  logic [N-1:0]  r_m;
  logic [E-1:0]  r_e;
  logic [LW-1:0] r_cnt;
  logic [N-1:0]  r_result;

  logic          w_accept;
  logic          w_cap;
  logic          w_dec;
  logic          w_mul_start;
  logic [LW-1:0] w_idx;
  logic [E-1:0]  w_shift;
  logic          w_bit;
  logic          w_last;

  // r_cnt holds the number of bits still to scan; the current bit is r_cnt-1.
  assign w_idx    = r_cnt - LW'(1);
  assign w_shift  = r_e >> w_idx;
  assign w_bit    = w_shift[0];
  assign w_last   = (r_cnt == LW'(1));
  assign w_accept = (r_state == IDLE) && start;

  always_comb begin
    w_next      = r_state;
    w_sel       = SEL_SQ;
    w_mul_start = 1'b0;
    w_cap       = 1'b0;
    w_dec       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next = (in_elen == '0) ? OUT_GO : SQ_GO;
      end
      SQ_GO: begin
        w_mul_start = 1'b1;
        w_next      = SQ_WAIT;
      end
      SQ_WAIT: begin
        if (mul_done) begin
          w_cap = 1'b1;
          if (w_bit) begin
            w_next = MUL_GO;
          end else begin
            w_dec  = 1'b1;
            w_next = w_last ? OUT_GO : SQ_GO;
          end
        end
      end
      MUL_GO: begin
        w_sel       = SEL_MUL;
        w_mul_start = 1'b1;
        w_next      = MUL_WAIT;
      end
      MUL_WAIT: begin
        w_sel = SEL_MUL;
        if (mul_done) begin
          w_cap  = 1'b1;
          w_dec  = 1'b1;
          w_next = w_last ? OUT_GO : SQ_GO;
        end
      end
      OUT_GO: begin
        w_sel       = SEL_ONE;
        w_mul_start = 1'b1;
        w_next      = OUT_WAIT;
      end
      OUT_WAIT: begin
        w_sel = SEL_ONE;
        if (mul_done) begin
          w_cap  = 1'b1;
          w_next = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_x      <= '0;
      r_m      <= '0;
      r_e      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a   <= in_r;
        r_x   <= in_x;
        r_m   <= in_m;
        r_e   <= in_e;
        r_cnt <= in_elen;
      end
      if (w_cap) r_a <= mul_result;
      if (w_cap && (r_state == OUT_WAIT)) r_result <= mul_result;
      if (w_dec) r_cnt <= r_cnt - LW'(1);
    end
  end

  // A only changes on the mul_done edge, so operands stay stable through it.
  always_comb begin
    mul_b = r_a;
    case (w_sel)
      SEL_SQ:  mul_b = r_a;
      SEL_MUL: mul_b = r_x;
      SEL_ONE: mul_b = N'(1);
      default: mul_b = r_a;
    endcase
  end

  assign mul_a     = r_a;
  assign mul_m     = r_m;
  assign mul_start = w_mul_start;
  assign result    = r_result;
  assign done      = (r_state == DONE);
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_montgomery_exp_ctrl.sv
// Self-checking bench for montgomery_exp_ctrl with a behavioural multiplier
// returning (a*b) mod m after a programmable latency. in_r = 1, so the
// Montgomery factor is 1 and the expected result is plain x^e mod m.
module tb_montgomery_exp_ctrl;

  localparam int unsigned N  = 16;
  localparam int unsigned E  = 8;
  localparam int unsigned LW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [N-1:0]  in_x, in_r, in_m;
  logic [E-1:0]  in_e;
  logic [LW-1:0] in_elen;
  logic [N-1:0]  result;
  logic          done, busy, mul_start;
  logic [N-1:0]  mul_a, mul_b, mul_m;
  logic [N-1:0]  mul_result;
  logic          mul_done;

  montgomery_exp_ctrl #(.N(N), .E(E), .LW(LW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_x(in_x), .in_r(in_r), .in_m(in_m), .in_e(in_e), .in_elen(in_elen),
    .result(result), .done(done), .busy(busy),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_m(mul_m),
    .mul_result(mul_result), .mul_done(mul_done)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural multiplier ----------------
  typedef struct { logic [N-1:0] a, b, m; } op_t;
  op_t             ops_q[$];
  longint unsigned cyc = 0;
  longint unsigned due = 0;
  bit              pend = 0;
  logic [N-1:0]    cap_a, cap_b, cap_m;
  logic            m_done = 1'b0;
  logic [N-1:0]    m_res = '0;
  int unsigned     n_mulstart = 0;
  int unsigned     n_unstable = 0;
  int unsigned     lat_cfg = 3;
  logic            spur = 1'b0;

  assign mul_done   = m_done | spur;
  assign mul_result = m_res;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      pend = 0;
      m_done <= 1'b0;
    end else begin
      if (m_done && (mul_a !== cap_a || mul_b !== cap_b || mul_m !== cap_m))
        n_unstable = n_unstable + 1;
      m_done <= 1'b0;
      if (mul_start) begin
        cap_a = mul_a; cap_b = mul_b; cap_m = mul_m;
        ops_q.push_back('{a: mul_a, b: mul_b, m: mul_m});
        n_mulstart = n_mulstart + 1;
        due  = cyc + longint'(lat_cfg);
        pend = 1;
      end
      if (pend && (cyc + 1 == due)) begin
        m_done <= 1'b1;
        m_res  <= N'((longint'(cap_a) * longint'(cap_b)) % longint'(cap_m));
        pend = 0;
      end
    end
  end

  // ---------------- checking ----------------
  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: right-to-left binary exponentiation over the scanned bits.
  function automatic longint unsigned powmod(input longint unsigned x, input logic [E-1:0] e,
                                             input int unsigned elen, input longint unsigned m);
    longint unsigned r = 1 % m;
    longint unsigned b = x % m;
    for (int unsigned i = 0; i < elen; i++) begin
      if (e[i]) r = (r * b) % m;
      b = (b * b) % m;
    end
    return r;
  endfunction

  task automatic run_one(input string tag, input logic [N-1:0] x, input logic [E-1:0] e,
                         input logic [LW-1:0] elen, input logic [N-1:0] m, input int unsigned lat,
                         input bit inj_st, input bit inj_sp,
                         input logic [N-1:0] exp_res, input int unsigned exp_nmul);
    longint unsigned t0, acc;
    longint unsigned ea[$], eb[$];
    int unsigned base_n, base_q, base_u, busy_bad, bad;
    bit got, spur_fired;
    lat_cfg = lat;
    @(negedge clk);
    base_n = n_mulstart; base_q = ops_q.size(); base_u = n_unstable;
    in_x = x; in_e = e; in_elen = elen; in_m = m; in_r = 1; start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    in_x = N'($urandom); in_e = E'($urandom); in_elen = LW'($urandom);
    in_m = N'($urandom); in_r = N'($urandom);
    got = 0; busy_bad = 0; spur_fired = 0;
    for (int k = 0; k < 400; k++) begin
      if (done) begin got = 1; break; end
      if (!busy) busy_bad++;
      if (inj_sp && !spur_fired && mul_start) begin spur = 1'b1; spur_fired = 1; end
      if (inj_st && k == 6) start = 1'b1;
      @(negedge clk);
      spur = 1'b0; start = 1'b0;
    end
    chk({tag, " timeout"}, {63'd0, !got}, 64'd0);
    chk({tag, " result"}, 64'(result), 64'(exp_res));
    chk({tag, " mul count"}, 64'(n_mulstart - base_n), 64'(exp_nmul));
    chk({tag, " latency"}, cyc - t0 + 1, 64'(2 + exp_nmul * (lat + 1)));
    chk({tag, " busy during run"}, 64'(busy_bad), 64'd0);
    chk({tag, " operand stability"}, 64'(n_unstable - base_u), 64'd0);
    // Expected operand pairs: square (A,A), multiply (A,X), convert (A,1).
    acc = 1;
    for (int i = int'(elen) - 1; i >= 0; i--) begin
      ea.push_back(acc); eb.push_back(acc); acc = (acc * acc) % m;
      if (e[i]) begin ea.push_back(acc); eb.push_back(x); acc = (acc * x) % m; end
    end
    ea.push_back(acc); eb.push_back(1);
    bad = 0;
    if (ops_q.size() - base_q != ea.size()) bad++;
    else
      for (int j = 0; j < ea.size(); j++)
        if (64'(ops_q[base_q + j].a) != ea[j] || 64'(ops_q[base_q + j].b) != eb[j] ||
            ops_q[base_q + j].m !== m) bad++;
    chk({tag, " operand sequence"}, 64'(bad), 64'd0);
    @(negedge clk);
    chk({tag, " done pulse width"}, {63'd0, done}, 64'd0);
    chk({tag, " busy after done"}, {63'd0, busy}, 64'd0);
    chk({tag, " result held"}, 64'(result), 64'(exp_res));
  endtask

  typedef struct {
    logic [N-1:0]  x;
    logic [E-1:0]  e;
    logic [LW-1:0] elen;
    logic [N-1:0]  m;
    int unsigned   lat;
    bit            inj_st, inj_sp;
    logic [N-1:0]  exp_res;
    int unsigned   exp_nmul;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [N-1:0]  rx, rm;
    logic [E-1:0]  re;
    logic [LW-1:0] rl;
    int unsigned   rlat, waited;

    vecs[0] = '{x: 3, e: 8'h05, elen: 3, m: 7,   lat: 3, inj_st: 0, inj_sp: 0, exp_res: 5,  exp_nmul: 6};
    vecs[1] = '{x: 2, e: 8'h0D, elen: 4, m: 11,  lat: 2, inj_st: 0, inj_sp: 0, exp_res: 8,  exp_nmul: 8};
    vecs[2] = '{x: 9, e: 8'hA5, elen: 0, m: 13,  lat: 3, inj_st: 0, inj_sp: 0, exp_res: 1,  exp_nmul: 1};
    vecs[3] = '{x: 3, e: 8'h05, elen: 3, m: 7,   lat: 3, inj_st: 1, inj_sp: 1, exp_res: 5,  exp_nmul: 6};
    vecs[4] = '{x: 2, e: 8'h80, elen: 8, m: 255, lat: 1, inj_st: 0, inj_sp: 0, exp_res: 1,  exp_nmul: 10};
    vecs[5] = '{x: 3, e: 8'hFF, elen: 8, m: 16,  lat: 2, inj_st: 0, inj_sp: 0, exp_res: 11, exp_nmul: 17};
    vecs[6] = '{x: 3, e: 8'hF5, elen: 3, m: 7,   lat: 4, inj_st: 0, inj_sp: 0, exp_res: 5,  exp_nmul: 6};

    reset = 1'b1; start = 1'b0;
    in_x = '0; in_r = '0; in_m = '0; in_e = '0; in_elen = '0;
    repeat (3) @(negedge clk);
    chk("reset done", {63'd0, done}, 64'd0);
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset mul_start", {63'd0, mul_start}, 64'd0);
    chk("reset result", 64'(result), 64'd0);
    reset = 1'b0;
    // A stray mul_done while idle must not start anything.
    spur = 1'b1; @(negedge clk); spur = 1'b0; @(negedge clk);
    chk("idle spurious mul_done", {62'd0, busy, mul_start}, 64'd0);

    for (int i = 0; i < 7; i++)
      run_one($sformatf("vec%0d", i), vecs[i].x, vecs[i].e, vecs[i].elen, vecs[i].m,
              vecs[i].lat, vecs[i].inj_st, vecs[i].inj_sp, vecs[i].exp_res, vecs[i].exp_nmul);

    // Reset while waiting on the first multiply (A,X), then a clean rerun.
    lat_cfg = 3;
    @(negedge clk);
    waited = n_mulstart;
    in_x = 3; in_e = 8'h05; in_elen = 3; in_m = 7; in_r = 1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 100 && n_mulstart < waited + 2; k++) @(negedge clk);
    chk("reached MUL_WAIT", 64'(n_mulstart - waited), 64'd2);
    reset = 1'b1;
    @(negedge clk);
    chk("mid-run reset outputs", {60'd0, done, busy, mul_start, |result}, 64'd0);
    chk("mid-run reset accumulator", 64'(mul_a), 64'd0);
    reset = 1'b0;
    run_one("after reset", 3, 8'h05, 3, 7, 3, 0, 0, 5, 6);

    for (int r = 0; r < 20; r++) begin
      rm   = N'($urandom_range(2, 65535));
      rx   = N'($urandom % rm);
      re   = E'($urandom);
      rl   = LW'($urandom_range(0, E));
      rlat = $urandom_range(1, 5);
      run_one($sformatf("rand%0d", r), rx, re, rl, rm, rlat, r[0], r[1],
              N'(powmod(rx, re, rl, rm)),
              rl + $countones(re & E'((9'd1 << rl) - 9'd1)) + 1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
